multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle RV32IM core.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives the datapath mux selects, write strobes and the imm_src select of the immediate extender.
- Handshakes with instruction/data memory (mem_ready) and with the iterative multiply/divide unit (md_start/md_done).

---
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32IM core: one instruction at a time through fetch/decode/execute/memory/writeback.
// Optional build macro ILLEGAL_TRAP_EN adds illegal_instr and an absorbing TRAP state for unknown opcodes.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       branch_taken,
  input  logic       md_done,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       md_start
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB,
    BRANCH, JAL, JALR, LINKWB, LUI, AUIPC, MDSTART, MDWAIT, MDWB, TRAP
  } state_t;

  state_t state, state_next;
  logic   pc_write_c, ir_write_c, mem_write_c, reg_write_c, md_start_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // Memory handshake: a request is held stable until mem_ready is seen high; that cycle completes it.
  always_comb begin
    state_next  = state;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    md_start_c  = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    imm_src     = IMM_I;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write_c = mem_ready;
        ir_write_c = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == 7'b1101111) ? IMM_J : IMM_B;
        case (op)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011: state_next = (funct7 == 7'b0000001) ? MDSTART : EXECR;
          7'b0010011: state_next = EXECI;
          7'b1100011: state_next = BRANCH;
          7'b1101111: state_next = JAL;
          7'b1100111: state_next = JALR;
          7'b0110111: state_next = LUI;
          7'b0010111: state_next = AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:    state_next = TRAP;
`else
          default:    state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = op[5] ? IMM_S : IMM_I;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write_c = branch_taken;
        state_next = FETCH;
      end
      JAL: begin
        // ALUOut already holds old_pc + imm_J from DECODE.
        pc_write_c = 1'b1;
        state_next = LINKWB;
      end
      JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write_c = 1'b1;
        state_next = LINKWB;
      end
      LINKWB: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        imm_src    = IMM_U;
        state_next = ALUWB;
      end
      AUIPC: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        imm_src    = IMM_U;
        state_next = ALUWB;
      end
      MDSTART: begin
        md_start_c = 1'b1;
        state_next = MDWAIT;
      end
      MDWAIT: begin
        if (md_done) state_next = MDWB;
      end
      MDWB: begin
        result_src  = 2'b11;
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign md_start  = md_start_c  & rst_n;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state == TRAP) & rst_n;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle against hand-computed output vectors.
module tb_multicycle_control;

  localparam int IMM_I = 0;
  localparam int IMM_S = 1;
  localparam int IMM_B = 2;
  localparam int IMM_J = 3;
  localparam int IMM_U = 4;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [6:0] funct7 = 7'd0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       md_done = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, md_start;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .funct7       (funct7),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .md_done      (md_done),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_src      (imm_src),
    .md_start     (md_start)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

  logic [31:0] outv;
  assign outv = {15'd0, pc_write, ir_write, adr_src, mem_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, imm_src, md_start};

  int total = 0;
  int bad = 0;
  int rw_cnt = 0;
  int ms_cnt = 0;

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ov(input int pw, input int iw, input int as, input int mw,
                                     input int rw, input int rs, input int a, input int b,
                                     input int ao, input int imm, input int ms);
    return {15'd0, pw[0], iw[0], as[0], mw[0], rw[0], rs[1:0], a[1:0], b[1:0], ao[1:0],
            imm[2:0], ms[0]};
  endfunction

  function automatic logic [31:0] f_fetch(input int mr);
    return ov(mr, mr, 0, 0, 0, 'b10, 'b00, 'b10, 'b00, IMM_I, 0);
  endfunction

  function automatic logic [31:0] f_decode(input int imm);
    return ov(0, 0, 0, 0, 0, 'b00, 'b01, 'b01, 'b00, imm, 0);
  endfunction

  function automatic logic [31:0] f_idle();
    return ov(0, 0, 0, 0, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 0);
  endfunction

  // driver: inputs are set by the caller, checked 1 time unit later, then advance one cycle
  task automatic cyc(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, outv, exp);
    if (reg_write) rw_cnt++;
    if (md_start) ms_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", outv, f_fetch(0));
    mem_ready = 1'b1;
    #1;
    chk("rst_gate_mr", outv, f_fetch(0));
    rst_n = 1'b1;
    #1;
    chk("rel_pcw_hi", 32'(pc_write), 32'd1);
    mem_ready = 1'b0;
    #1;
    chk("rel_pcw_lo", 32'(pc_write), 32'd0);
    @(posedge clk);
    #1;

    // reset in MEMWRITE with mem_ready high
    op = 7'b0100011;
    mem_ready = 1'b1;
    cyc("rsw_fetch", f_fetch(1));
    cyc("rsw_decode", f_decode(IMM_B));
    cyc("rsw_memadr", ov(0, 0, 0, 0, 0, 'b00, 'b10, 'b01, 'b00, IMM_S, 0));
    #1;
    chk("rsw_memw_on", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsw_memw_off", 32'(mem_write), 32'd0);
    chk("rsw_vec", outv, f_fetch(0));
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rsw_after_rel", outv, f_fetch(0));
    mem_ready = 1'b1;
    #1;
    chk("rsw_pcw_follow", 32'(pc_write), 32'd1);

    // lw with memory wait states
    op = 7'b0000011;
    rw_cnt = 0;
    mem_ready = 1'b0;
    repeat (3) cyc("lw_fetch_wait", f_fetch(0));
    mem_ready = 1'b1;
    cyc("lw_fetch", f_fetch(1));
    cyc("lw_decode", f_decode(IMM_B));
    cyc("lw_memadr", ov(0, 0, 0, 0, 0, 'b00, 'b10, 'b01, 'b00, IMM_I, 0));
    mem_ready = 1'b0;
    repeat (2) cyc("lw_memread_wait", ov(0, 0, 1, 0, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    mem_ready = 1'b1;
    cyc("lw_memread", ov(0, 0, 1, 0, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    cyc("lw_memwb", ov(0, 0, 0, 0, 1, 'b01, 'b00, 'b00, 'b00, IMM_I, 0));
    chk("lw_rw_cnt", rw_cnt, 32'd1);
    mem_ready = 1'b0;
    cyc("lw_back_fetch", f_fetch(0));

    // sw
    op = 7'b0100011;
    rw_cnt = 0;
    mem_ready = 1'b1;
    cyc("sw_fetch", f_fetch(1));
    cyc("sw_decode", f_decode(IMM_B));
    cyc("sw_memadr", ov(0, 0, 0, 0, 0, 'b00, 'b10, 'b01, 'b00, IMM_S, 0));
    mem_ready = 1'b0;
    repeat (2) cyc("sw_memwrite_wait", ov(0, 0, 1, 1, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    mem_ready = 1'b1;
    cyc("sw_memwrite", ov(0, 0, 1, 1, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    chk("sw_rw_cnt", rw_cnt, 32'd0);
    mem_ready = 1'b0;
    cyc("sw_back_fetch", f_fetch(0));

    // branches, taken then not taken
    op = 7'b1100011;
    for (int t = 1; t >= 0; t--) begin
      branch_taken = t[0];
      mem_ready = 1'b1;
      cyc("br_fetch", f_fetch(1));
      cyc("br_decode", f_decode(IMM_B));
      cyc("br_branch", ov(t, 0, 0, 0, 0, 'b00, 'b10, 'b00, 'b01, IMM_I, 0));
      mem_ready = 1'b0;
      cyc("br_back_fetch", f_fetch(0));
    end
    branch_taken = 1'b0;

    // jal / jalr
    op = 7'b1101111;
    mem_ready = 1'b1;
    cyc("jal_fetch", f_fetch(1));
    cyc("jal_decode", f_decode(IMM_J));
    cyc("jal_jal", ov(1, 0, 0, 0, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    cyc("jal_linkwb", ov(0, 0, 0, 0, 1, 'b10, 'b01, 'b10, 'b00, IMM_I, 0));
    mem_ready = 1'b0;
    cyc("jal_back_fetch", f_fetch(0));
    op = 7'b1100111;
    mem_ready = 1'b1;
    cyc("jalr_fetch", f_fetch(1));
    cyc("jalr_decode", f_decode(IMM_B));
    cyc("jalr_jalr", ov(1, 0, 0, 0, 0, 'b10, 'b10, 'b01, 'b00, IMM_I, 0));
    cyc("jalr_linkwb", ov(0, 0, 0, 0, 1, 'b10, 'b01, 'b10, 'b00, IMM_I, 0));

    // R, I, LUI, AUIPC all end in ALUWB
    op = 7'b0110011;
    funct7 = 7'b0000000;
    cyc("add_fetch", f_fetch(1));
    cyc("add_decode", f_decode(IMM_B));
    cyc("add_execr", ov(0, 0, 0, 0, 0, 'b00, 'b10, 'b00, 'b10, IMM_I, 0));
    cyc("add_aluwb", ov(0, 0, 0, 0, 1, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    op = 7'b0010011;
    cyc("addi_fetch", f_fetch(1));
    cyc("addi_decode", f_decode(IMM_B));
    cyc("addi_execi", ov(0, 0, 0, 0, 0, 'b00, 'b10, 'b01, 'b10, IMM_I, 0));
    cyc("addi_aluwb", ov(0, 0, 0, 0, 1, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    op = 7'b0110111;
    cyc("lui_fetch", f_fetch(1));
    cyc("lui_decode", f_decode(IMM_B));
    cyc("lui_lui", ov(0, 0, 0, 0, 0, 'b00, 'b11, 'b01, 'b00, IMM_U, 0));
    cyc("lui_aluwb", ov(0, 0, 0, 0, 1, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));
    op = 7'b0010111;
    cyc("auipc_fetch", f_fetch(1));
    cyc("auipc_decode", f_decode(IMM_B));
    cyc("auipc_auipc", ov(0, 0, 0, 0, 0, 'b00, 'b01, 'b01, 'b00, IMM_U, 0));
    cyc("auipc_aluwb", ov(0, 0, 0, 0, 1, 'b00, 'b00, 'b00, 'b00, IMM_I, 0));

    // mul, md_done pulses 6 cycles after md_start; an early md_done in MDSTART is ignored
    op = 7'b0110011;
    funct7 = 7'b0000001;
    ms_cnt = 0;
    cyc("mul_fetch", f_fetch(1));
    cyc("mul_decode", f_decode(IMM_B));
    md_done = 1'b1;
    cyc("mul_mdstart", ov(0, 0, 0, 0, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 1));
    md_done = 1'b0;
    repeat (5) cyc("mul_mdwait", f_idle());
    md_done = 1'b1;
    cyc("mul_mdwait_done", f_idle());
    md_done = 1'b0;
    cyc("mul_mdwb", ov(0, 0, 0, 0, 1, 'b11, 'b00, 'b00, 'b00, IMM_I, 0));
    chk("mul_ms_cnt", ms_cnt, 32'd1);
    mem_ready = 1'b0;
    cyc("mul_back_fetch", f_fetch(0));

    // reset while waiting on muldiv abandons it
    mem_ready = 1'b1;
    cyc("mulr_fetch", f_fetch(1));
    cyc("mulr_decode", f_decode(IMM_B));
    cyc("mulr_mdstart", ov(0, 0, 0, 0, 0, 'b00, 'b00, 'b00, 'b00, IMM_I, 1));
    cyc("mulr_mdwait", f_idle());
    rst_n = 1'b0;
    mem_ready = 1'b0;
    cyc("mulr_in_reset", f_fetch(0));
    rst_n = 1'b1;
    md_done = 1'b1;
    cyc("mulr_after_rel", f_fetch(0));
    md_done = 1'b0;
    cyc("mulr_still_fetch", f_fetch(0));

    // unknown opcode
    op = 7'b1111111;
    funct7 = 7'b0000000;
    mem_ready = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    chk("ill_low_fetch", 32'(illegal_instr), 32'd0);
`endif
    cyc("ill_fetch", f_fetch(1));
    cyc("ill_decode", f_decode(IMM_B));
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("ill_flag", 32'(illegal_instr), 32'd1);
      cyc("ill_trap", f_idle());
    end
    rst_n = 1'b0;
    #1;
    chk("ill_flag_rst", 32'(illegal_instr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ill_flag_rel", 32'(illegal_instr), 32'd0);
    cyc("ill_fetch_rel", f_fetch(1));
`else
    mem_ready = 1'b0;
    cyc("ill_nop_fetch", f_fetch(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
